// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional odd/even parity, 1 or 2 stop bits,
// with 3-sample majority voting, false-start rejection and parity/framing/break reporting.
module uart_rx_cfg #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Rx_Active
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = 4;
    localparam int unsigned MID   = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_SMP0  = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_SMP1  = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_DEC   = CNT_W'(MID + 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic             PAR_EN    = (PARITY_MODE != 0);
    localparam logic             PAR_ODD   = (PARITY_MODE == 1);
    localparam logic             PAR_EVEN  = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic                 sync_q;
    logic                 s;
    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt;
    logic [1:0]           smp, smp_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 par_acc, par_nxt;
    logic                 any_one, any_one_nxt;
    logic                 stop_err, stop_err_nxt;
    logic                 dv_nxt, perr_nxt, ferr_nxt, brk_nxt, active_nxt;
    logic [DATA_BITS-1:0] byte_nxt;
    logic                 bit_maj;
    logic                 at_dec;
    logic                 at_last;

    assign bit_maj = (smp[0] & smp[1]) | (smp[0] & s) | (smp[1] & s);
    assign at_dec  = (cnt == CNT_DEC);
    assign at_last = (cnt == CNT_LAST);

    // State and datapath registers
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            sync_q       <= 1'b1;
            s            <= 1'b1;
            state        <= S_IDLE;
            cnt          <= '0;
            idx          <= '0;
            smp          <= 2'b11;
            shreg        <= '0;
            par_acc      <= 1'b0;
            any_one      <= 1'b0;
            stop_err     <= 1'b0;
            o_Rx_DV      <= 1'b0;
            o_Rx_Byte    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Break      <= 1'b0;
            o_Rx_Active  <= 1'b0;
        end else begin
            sync_q       <= i_Rx_Serial;
            s            <= sync_q;
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            idx          <= idx_nxt;
            smp          <= smp_nxt;
            shreg        <= shreg_nxt;
            par_acc      <= par_nxt;
            any_one      <= any_one_nxt;
            stop_err     <= stop_err_nxt;
            o_Rx_DV      <= dv_nxt;
            o_Rx_Byte    <= byte_nxt;
            o_Parity_Err <= perr_nxt;
            o_Frame_Err  <= ferr_nxt;
            o_Break      <= brk_nxt;
            o_Rx_Active  <= active_nxt;
        end
    end

    // Next-state, bit decisions and result capture
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = at_last ? '0 : cnt + CNT_W'(1);
        idx_nxt      = idx;
        smp_nxt      = smp;
        shreg_nxt    = shreg;
        par_nxt      = par_acc;
        any_one_nxt  = any_one;
        stop_err_nxt = stop_err;
        dv_nxt       = 1'b0;
        byte_nxt     = o_Rx_Byte;
        perr_nxt     = o_Parity_Err;
        ferr_nxt     = o_Frame_Err;
        brk_nxt      = o_Break;

        if (cnt == CNT_SMP0) smp_nxt[0] = s;
        if (cnt == CNT_SMP1) smp_nxt[1] = s;

        case (state)
            S_IDLE: begin
                cnt_nxt      = '0;
                idx_nxt      = '0;
                par_nxt      = 1'b0;
                any_one_nxt  = 1'b0;
                stop_err_nxt = 1'b0;
                // The detection cycle is count 0 of the start bit
                if (!s) begin
                    state_nxt = S_START;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            S_START: begin
                if (at_dec && bit_maj) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (at_last) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (at_dec) begin
                    shreg_nxt   = {bit_maj, shreg[DATA_BITS-1:1]};
                    par_nxt     = par_acc ^ bit_maj;
                    any_one_nxt = any_one | bit_maj;
                end
                if (at_last) begin
                    if (idx == DATA_LAST) begin
                        idx_nxt   = '0;
                        state_nxt = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (at_dec) begin
                    par_nxt     = par_acc ^ bit_maj;
                    any_one_nxt = any_one | bit_maj;
                end
                if (at_last) state_nxt = S_STOP;
            end
            S_STOP: begin
                // Report at the last stop decision so a back-to-back start is not missed
                if (at_dec) begin
                    if (idx == STOP_LAST) begin
                        dv_nxt    = 1'b1;
                        byte_nxt  = shreg;
                        perr_nxt  = (PAR_ODD & ~par_acc) | (PAR_EVEN & par_acc);
                        ferr_nxt  = stop_err | ~bit_maj;
                        brk_nxt   = ~(any_one | bit_maj);
                        state_nxt = s ? S_IDLE : S_WAIT_HIGH;
                        cnt_nxt   = '0;
                    end else begin
                        stop_err_nxt = stop_err | ~bit_maj;
                        any_one_nxt  = any_one | bit_maj;
                    end
                end else if (at_last) begin
                    idx_nxt = idx + IDX_W'(1);
                end
            end
            S_WAIT_HIGH: begin
                cnt_nxt = '0;
                if (s) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        active_nxt = (state_nxt == S_START) || (state_nxt == S_DATA) ||
                     (state_nxt == S_PARITY) || (state_nxt == S_STOP);
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three frame formats (8N1, 8E1, 7O2) driven from a line model,
// checked with a vector table, directed corner sequences and randomized frames.
module tb_uart_rx_cfg;

    localparam int CPB0 = 87, DB0 = 8, PM0 = 0, SB0 = 1;
    localparam int CPB1 = 16, DB1 = 8, PM1 = 2, SB1 = 1;
    localparam int CPB2 = 10, DB2 = 7, PM2 = 1, SB2 = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rx;
    wire  [2:0] dv, perr, ferr, brk, act;
    wire  [7:0] byte0, byte1;
    wire  [6:0] byte2;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB0), .DATA_BITS(DB0), .PARITY_MODE(PM0), .STOP_BITS(SB0)) u_8n1 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[0]), .o_Rx_DV(dv[0]), .o_Rx_Byte(byte0),
        .o_Parity_Err(perr[0]), .o_Frame_Err(ferr[0]), .o_Break(brk[0]), .o_Rx_Active(act[0]));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB1), .DATA_BITS(DB1), .PARITY_MODE(PM1), .STOP_BITS(SB1)) u_8e1 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[1]), .o_Rx_DV(dv[1]), .o_Rx_Byte(byte1),
        .o_Parity_Err(perr[1]), .o_Frame_Err(ferr[1]), .o_Break(brk[1]), .o_Rx_Active(act[1]));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB2), .DATA_BITS(DB2), .PARITY_MODE(PM2), .STOP_BITS(SB2)) u_7o2 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[2]), .o_Rx_DV(dv[2]), .o_Rx_Byte(byte2),
        .o_Parity_Err(perr[2]), .o_Frame_Err(ferr[2]), .o_Break(brk[2]), .o_Rx_Active(act[2]));

    typedef struct {
        int         d;
        int         cyc;
        logic [8:0] byt;
        logic       perr;
        logic       ferr;
        logic       brk;
    } rec_t;

    typedef struct {
        int         d;
        logic [8:0] data;
        bit         pflip;
        logic [1:0] stop_low;
        int         gbit;
        int         goff;
        int         gap;
        logic [8:0] ebyte;
        bit         eperr;
        bit         eferr;
        bit         ebrk;
    } vec_t;

    rec_t got_q[$];
    rec_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Every DV cycle seen on any receiver
    always @(negedge clk) begin
        if (dv[0]) got_q.push_back('{0, cyc, {1'b0, byte0}, perr[0], ferr[0], brk[0]});
        if (dv[1]) got_q.push_back('{1, cyc, {1'b0, byte1}, perr[1], ferr[1], brk[1]});
        if (dv[2]) got_q.push_back('{2, cyc, {2'b0, byte2}, perr[2], ferr[2], brk[2]});
    end

    function automatic int cpb_of(input int d);
        return (d == 0) ? CPB0 : (d == 1) ? CPB1 : CPB2;
    endfunction
    function automatic int db_of(input int d);
        return (d == 0) ? DB0 : (d == 1) ? DB1 : DB2;
    endfunction
    function automatic int pm_of(input int d);
        return (d == 0) ? PM0 : (d == 1) ? PM1 : PM2;
    endfunction
    function automatic int sb_of(input int d);
        return (d == 0) ? SB0 : (d == 1) ? SB1 : SB2;
    endfunction
    function automatic int flen_of(input int d);
        return 1 + db_of(d) + ((pm_of(d) != 0) ? 1 : 0) + sb_of(d);
    endfunction
    // Cycle in which DV is expected, counted from the cycle the raw line fell
    function automatic int dv_cyc_of(input int d, input int t_fall);
        return t_fall + 2 + (flen_of(d) - 1) * cpb_of(d) + cpb_of(d) / 2 + 2;
    endfunction

    task automatic chk(input string nm, input int act_v, input int exp_v);
        n_chk++;
        if (act_v == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act_v, exp_v);
    endtask

    // Drive one frame on line d (called at a negedge, returns at a negedge)
    task automatic send_frame(input int d, input logic [8:0] data, input bit pflip,
                              input logic [1:0] stop_low, input int gbit, input int goff,
                              input int gap, input bit model, output int t_fall);
        int          cpb = cpb_of(d);
        int          db  = db_of(d);
        int          pm  = pm_of(d);
        int          sb  = sb_of(d);
        int          f   = flen_of(d);
        logic [12:0] bits;
        logic        dpar;
        rec_t        e;
        bits = '0;
        dpar = 1'b0;
        for (int i = 0; i < db; i++) begin
            bits[1+i] = data[i];
            dpar      = dpar ^ data[i];
        end
        if (pm != 0) bits[1+db] = ((pm == 1) ? ~dpar : dpar) ^ pflip;
        for (int i = 0; i < sb; i++) bits[f-sb+i] = ~stop_low[i];
        t_fall = cyc;
        for (int j = 0; j < f; j++) begin
            for (int o = 0; o < cpb; o++) begin
                rx[d] = bits[j] ^ ((j == gbit) && (o == goff));
                @(negedge clk);
            end
        end
        rx[d] = 1'b1;
        repeat (gap * cpb) @(negedge clk);
        if (model) begin
            e.d    = d;
            e.cyc  = dv_cyc_of(d, t_fall);
            e.byt  = data & 9'((1 << db) - 1);
            e.perr = (pm == 0) ? 1'b0 : (pm == 1) ? ((dpar ^ bits[1+db]) == 1'b0)
                                                   : ((dpar ^ bits[1+db]) == 1'b1);
            e.ferr = 1'b0;
            for (int i = 0; i < sb; i++) if (stop_low[i]) e.ferr = 1'b1;
            e.brk = 1'b1;
            for (int j = 1; j < f; j++) if (bits[j]) e.brk = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic check_queues(input string nm);
        int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        chk($sformatf("%s dv_count", nm), got_q.size(), exp_q.size());
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s[%0d] dut", nm, i), got_q[i].d, exp_q[i].d);
            chk($sformatf("%s[%0d] dv_cycle", nm, i), got_q[i].cyc, exp_q[i].cyc);
            chk($sformatf("%s[%0d] byte", nm, i), int'(got_q[i].byt), int'(exp_q[i].byt));
            chk($sformatf("%s[%0d] parity_err", nm, i), int'(got_q[i].perr), int'(exp_q[i].perr));
            chk($sformatf("%s[%0d] frame_err", nm, i), int'(got_q[i].ferr), int'(exp_q[i].ferr));
            chk($sformatf("%s[%0d] break", nm, i), int'(got_q[i].brk), int'(exp_q[i].brk));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int   t_fall;
        int   t;

        tbl[0] = '{0, 9'h03F, 1'b0, 2'b00, -1, 0, 1, 9'h03F, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1, 9'h0A5, 1'b0, 2'b00, -1, 0, 1, 9'h0A5, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1, 9'h0A5, 1'b1, 2'b00, -1, 0, 1, 9'h0A5, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{2, 9'h055, 1'b0, 2'b10, -1, 0, 1, 9'h055, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{2, 9'h02A, 1'b0, 2'b00, -1, 0, 0, 9'h02A, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{2, 9'h013, 1'b0, 2'b00, -1, 0, 1, 9'h013, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{0, 9'h000, 1'b0, 2'b00, 4, CPB0 / 2, 1, 9'h000, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        rx  = 3'b111;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset dv[%0d]", d), int'(dv[d]), 0);
            chk($sformatf("reset active[%0d]", d), int'(act[d]), 0);
            chk($sformatf("reset flags[%0d]", d), int'({perr[d], ferr[d], brk[d]}), 0);
        end
        chk("reset byte0", int'(byte0), 0);
        chk("reset byte2", int'(byte2), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Vector table; zero-time checks keep gap-0 entries back-to-back
        for (int i = 0; i < 7; i++) begin
            send_frame(tbl[i].d, tbl[i].data, tbl[i].pflip, tbl[i].stop_low, tbl[i].gbit,
                       tbl[i].goff, tbl[i].gap, 1'b0, t_fall);
            chk($sformatf("vec%0d dv_count", i), got_q.size(), 1);
            if (got_q.size() > 0) begin
                chk($sformatf("vec%0d dut", i), got_q[0].d, tbl[i].d);
                chk($sformatf("vec%0d dv_cycle", i), got_q[0].cyc, dv_cyc_of(tbl[i].d, t_fall));
                chk($sformatf("vec%0d byte", i), int'(got_q[0].byt), int'(tbl[i].ebyte));
                chk($sformatf("vec%0d parity_err", i), int'(got_q[0].perr), int'(tbl[i].eperr));
                chk($sformatf("vec%0d frame_err", i), int'(got_q[0].ferr), int'(tbl[i].eferr));
                chk($sformatf("vec%0d break", i), int'(got_q[0].brk), int'(tbl[i].ebrk));
            end
            got_q.delete();
        end

        // False start: 20 low cycles, rejected at the start-bit decision
        t = cyc;
        for (int o = 0; o < 60; o++) begin
            rx[0] = (o < 20) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (cyc - t == 2)  chk("false_start active_t0", int'(act[0]), 0);
            if (cyc - t == 3)  chk("false_start active_t1", int'(act[0]), 1);
            if (cyc - t == 46) chk("false_start active_cnt44", int'(act[0]), 1);
            if (cyc - t == 47) chk("false_start active_cnt45", int'(act[0]), 0);
        end
        repeat (11 * CPB0) @(negedge clk);
        chk("false_start dv_count", got_q.size(), 0);
        got_q.delete();

        // Break: line low for 12 bit times
        t = cyc;
        rx[0] = 1'b0;
        repeat (12 * CPB0) @(negedge clk);
        rx[0] = 1'b1;
        repeat (3 * CPB0) @(negedge clk);
        exp_q.push_back('{0, dv_cyc_of(0, t), 9'h000, 1'b0, 1'b1, 1'b1});
        check_queues("break");
        send_frame(0, 9'h0C3, 1'b0, 2'b00, -1, 0, 1, 1'b1, t_fall);
        check_queues("after_break");

        // Reset in the middle of data bit 4
        fork
            send_frame(0, 9'h0FF, 1'b0, 2'b00, -1, 0, 1, 1'b0, t_fall);
            begin
                repeat (5 * CPB0 + CPB0 / 2) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                chk("midreset byte_in_reset", int'(byte0), 0);
                chk("midreset active_in_reset", int'(act[0]), 0);
                rst = 1'b0;
            end
        join
        repeat (CPB0) @(negedge clk);
        chk("midreset dv_count", got_q.size(), 0);
        chk("midreset byte", int'(byte0), 0);
        chk("midreset flags", int'({perr[0], ferr[0], brk[0]}), 0);
        chk("midreset active", int'(act[0]), 0);
        got_q.delete();
        send_frame(0, 9'h081, 1'b0, 2'b00, -1, 0, 1, 1'b1, t_fall);
        check_queues("after_reset");

        // Randomized frames: errors, glitches at sample points, zero-gap streams
        for (int d = 0; d < 3; d++) begin
            int n = (d == 0) ? 3 : 15;
            for (int k = 0; k < n; k++) begin
                logic [8:0] data = 9'($urandom);
                bit         pflip;
                logic [1:0] sl;
                int         gbit = -1;
                int         goff = 0;
                int         gap  = $urandom_range(0, 2);
                if ($urandom_range(0, 7) == 0) data = '0;
                pflip = (pm_of(d) != 0) && ($urandom_range(0, 4) == 0);
                sl[0] = ($urandom_range(0, 4) == 0);
                sl[1] = ($urandom_range(0, 4) == 0);
                if (sb_of(d) == 1) sl[1] = 1'b0;
                if ($urandom_range(0, 1) == 1) begin
                    gbit = $urandom_range(1, db_of(d) + ((pm_of(d) != 0) ? 1 : 0));
                    goff = cpb_of(d) / 2 - 1 + $urandom_range(0, 2);
                end
                if (sl[sb_of(d)-1] && gap == 0) gap = 1;
                send_frame(d, data, pflip, sl, gbit, goff, gap, 1'b1, t_fall);
            end
            repeat (2 * cpb_of(d)) @(negedge clk);
            check_queues($sformatf("random_dut%0d", d));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
